// File: rtl/cntr8_pkg.sv
// Shared definitions for the 8-bit up/down counter: state codes and default width.
// The output stage imports this package too, so both sides decode the same encoding.
package cntr8_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [2:0] {
      IDLE = 3'b000,
      LOAD = 3'b001,
      INC  = 3'b010,
      INC2 = 3'b011,
      DEC  = 3'b100,
      DEC2 = 3'b101
   } state_t;

   // Codes 110 and 111 have no meaning; any state with both top bits set is illegal.
   function automatic logic is_legal(input state_t s);
      return (s[2:1] != 2'b11);
   endfunction

   function automatic logic is_up(input state_t s);
      return (s == INC) || (s == INC2);
   endfunction

   function automatic logic is_down(input state_t s);
      return (s == DEC) || (s == DEC2);
   endfunction

endpackage

// File: rtl/cntr8_if.sv
// Command and status bundle between the counter controller and its user.
// The master drives commands; the slave (the controller) returns state, count and wrap.
interface cntr8_if
   import cntr8_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);

   logic             clr;
   logic             load;
   logic             inc;
   logic [WIDTH-1:0] d_in;
   state_t           state;
   logic [WIDTH-1:0] cnt;
   logic             tc;

   modport master (
      output clr,
      output load,
      output inc,
      output d_in,
      input  state,
      input  cnt,
      input  tc
   );

   modport slave (
      input  clr,
      input  load,
      input  inc,
      input  d_in,
      output state,
      output cnt,
      output tc
   );

endinterface

// File: rtl/cntr8_ns.sv
// Next-state table for the counter controller; purely combinational.
// Priority is illegal-state recovery, then clr, then load, then direction.
module cntr8_ns
   import cntr8_pkg::*;
(
   input  state_t state,
   input  logic   clr,
   input  logic   load,
   input  logic   inc,
   output state_t next_state
);

   // INC/INC2 and DEC/DEC2 alternate while the direction holds; any other entry lands on the first phase.
   always_comb begin
      next_state = IDLE;
      if (!is_legal(state)) begin
         next_state = IDLE;
      end else if (clr) begin
         next_state = IDLE;
      end else if (load) begin
         next_state = LOAD;
      end else if (inc) begin
         next_state = (state == INC) ? INC2 : INC;
      end else begin
         next_state = (state == DEC) ? DEC2 : DEC;
      end
   end

endmodule

// File: rtl/cntr8_ctrl.sv
// Control side of the loadable up/down counter: state register, count register
// and a registered one-cycle wrap flag for chaining counters.
module cntr8_ctrl
   import cntr8_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
)
(
   input  logic     clk,
   input  logic     reset,
   cntr8_if.slave   bus
);

   state_t           state_r;
   state_t           cur_state;
   state_t           next_state;
   logic [WIDTH-1:0] cnt_r;
   logic [WIDTH-1:0] cnt_next;
   logic             tc_r;
   logic             tc_next;

   assign cur_state = state_r;

   cntr8_ns u_ns (
      .state      (cur_state),
      .clr        (bus.clr),
      .load       (bus.load),
      .inc        (bus.inc),
      .next_state (next_state)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state;
      end
   end

   // The count follows the state being entered, so a direction flip steps on the same edge.
   always_comb begin
      cnt_next = cnt_r;
      tc_next  = 1'b0;
      if (is_up(next_state)) begin
         cnt_next = cnt_r + WIDTH'(1);
         tc_next  = &cnt_r;
      end else if (is_down(next_state)) begin
         cnt_next = cnt_r - WIDTH'(1);
         tc_next  = ~|cnt_r;
      end else if (next_state == LOAD) begin
         cnt_next = bus.d_in;
      end else begin
         cnt_next = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_r <= '0;
         tc_r  <= 1'b0;
      end else begin
         cnt_r <= cnt_next;
         tc_r  <= tc_next;
      end
   end

   assign bus.state = cur_state;
   assign bus.cnt   = cnt_r;
   assign bus.tc    = tc_r;

endmodule

// File: tb/tb_cntr8_ctrl.sv
// Self-checking bench for cntr8_ctrl: directed scenarios plus randomized
// command streams compared against a mode/phase reference model.
module tb_cntr8_ctrl;
   import cntr8_pkg::*;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   // Reference model: mode 0=idle 1=load 2=up 3=down, phase alternates while direction holds.
   int   m_mode;
   int   m_phase;
   int   m_cnt;
   bit   m_tc;

   cntr8_if #(.WIDTH(8)) bus ();

   cntr8_ctrl #(.WIDTH(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic drive(input logic c, input logic l, input logic i, input logic [7:0] d);
      bus.clr  = c;
      bus.load = l;
      bus.inc  = i;
      bus.d_in = d;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [2:0] model_code();
      case (m_mode)
         0:       return 3'd0;
         1:       return 3'd1;
         2:       return 3'(2 + m_phase);
         default: return 3'(4 + m_phase);
      endcase
   endfunction

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      #3;
      n_checks++;
      if (bus.state !== 3'b000) begin n_fail++; $display("[TB] FAIL reset_state got=%b exp=000", bus.state); end
      n_checks++;
      if (bus.cnt !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_cnt got=%h exp=00", bus.cnt); end
      n_checks++;
      if (bus.tc !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_tc got=%b exp=0", bus.tc); end
      tick();
      reset = 1'b0;
      drive(1'b0, 1'b1, 1'b0, 8'h37);
      tick();
      n_checks++;
      if (bus.cnt !== 8'h37) begin n_fail++; $display("[TB] FAIL reset_preload got=%h exp=37", bus.cnt); end
      // Assert reset mid-cycle; outputs must clear before any further edge.
      #3;
      reset = 1'b1;
      #1;
      n_checks++;
      if (bus.state !== 3'b000) begin n_fail++; $display("[TB] FAIL async_reset_state got=%b exp=000", bus.state); end
      n_checks++;
      if (bus.cnt !== 8'h00) begin n_fail++; $display("[TB] FAIL async_reset_cnt got=%h exp=00", bus.cnt); end
      n_checks++;
      if (bus.tc !== 1'b0) begin n_fail++; $display("[TB] FAIL async_reset_tc got=%b exp=0", bus.tc); end
      tick();
      reset = 1'b0;
      drive(1'b0, 1'b1, 1'b0, 8'h5A);
      tick();
      n_checks++;
      if (bus.state !== 3'b001 || bus.cnt !== 8'h5A)
         begin n_fail++; $display("[TB] FAIL post_reset_load got=%b/%h exp=001/5a", bus.state, bus.cnt); end
   endtask

   task automatic test_load_count_up();
      logic [2:0] exp_state [4] = '{3'b010, 3'b011, 3'b010, 3'b011};
      logic [7:0] exp_cnt   [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
      logic       exp_tc    [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
      drive(1'b0, 1'b1, 1'b1, 8'hFD);
      tick();
      n_checks++;
      if (bus.state !== 3'b001 || bus.cnt !== 8'hFD || bus.tc !== 1'b0)
         begin n_fail++; $display("[TB] FAIL up_load got=%b/%h/%b exp=001/fd/0", bus.state, bus.cnt, bus.tc); end
      drive(1'b0, 1'b0, 1'b1, 8'h00);
      for (int k = 0; k < 4; k++) begin
         tick();
         n_checks++;
         if (bus.state !== exp_state[k] || bus.cnt !== exp_cnt[k] || bus.tc !== exp_tc[k])
            begin n_fail++; $display("[TB] FAIL up_step%0d got=%b/%h/%b exp=%b/%h/%b", k,
               bus.state, bus.cnt, bus.tc, exp_state[k], exp_cnt[k], exp_tc[k]); end
      end
   endtask

   task automatic test_count_down();
      logic [2:0] exp_state [3] = '{3'b100, 3'b101, 3'b100};
      logic [7:0] exp_cnt   [3] = '{8'h00, 8'hFF, 8'hFE};
      logic       exp_tc    [3] = '{1'b0, 1'b1, 1'b0};
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      for (int k = 0; k < 3; k++) begin
         tick();
         n_checks++;
         if (bus.state !== exp_state[k] || bus.cnt !== exp_cnt[k] || bus.tc !== exp_tc[k])
            begin n_fail++; $display("[TB] FAIL down_step%0d got=%b/%h/%b exp=%b/%h/%b", k,
               bus.state, bus.cnt, bus.tc, exp_state[k], exp_cnt[k], exp_tc[k]); end
      end
   endtask

   task automatic test_priority();
      drive(1'b1, 1'b1, 1'b0, 8'hAA);
      tick();
      n_checks++;
      if (bus.state !== 3'b000 || bus.cnt !== 8'h00)
         begin n_fail++; $display("[TB] FAIL prio_clr got=%b/%h exp=000/00", bus.state, bus.cnt); end
      drive(1'b0, 1'b1, 1'b0, 8'hAA);
      tick();
      n_checks++;
      if (bus.state !== 3'b001 || bus.cnt !== 8'hAA)
         begin n_fail++; $display("[TB] FAIL prio_load got=%b/%h exp=001/aa", bus.state, bus.cnt); end
   endtask

   task automatic test_load_boundary();
      drive(1'b0, 1'b1, 1'b1, 8'hFF);
      tick();
      drive(1'b0, 1'b1, 1'b1, 8'h00);
      tick();
      n_checks++;
      if (bus.state !== 3'b001 || bus.cnt !== 8'h00 || bus.tc !== 1'b0)
         begin n_fail++; $display("[TB] FAIL load_ff_to_00 got=%b/%h/%b exp=001/00/0", bus.state, bus.cnt, bus.tc); end
      drive(1'b0, 1'b1, 1'b0, 8'hFF);
      tick();
      n_checks++;
      if (bus.state !== 3'b001 || bus.cnt !== 8'hFF || bus.tc !== 1'b0)
         begin n_fail++; $display("[TB] FAIL load_00_to_ff got=%b/%h/%b exp=001/ff/0", bus.state, bus.cnt, bus.tc); end
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      tick();
      n_checks++;
      if (bus.state !== 3'b000 || bus.cnt !== 8'h00 || bus.tc !== 1'b0)
         begin n_fail++; $display("[TB] FAIL clr_from_ff got=%b/%h/%b exp=000/00/0", bus.state, bus.cnt, bus.tc); end
   endtask

   task automatic test_direction_flip();
      drive(1'b0, 1'b1, 1'b0, 8'h0E);
      tick();
      drive(1'b0, 1'b0, 1'b1, 8'h00);
      tick();
      tick();
      n_checks++;
      if (bus.state !== 3'b011 || bus.cnt !== 8'h10)
         begin n_fail++; $display("[TB] FAIL flip_setup got=%b/%h exp=011/10", bus.state, bus.cnt); end
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      tick();
      n_checks++;
      if (bus.state !== 3'b100 || bus.cnt !== 8'h0F)
         begin n_fail++; $display("[TB] FAIL flip_down got=%b/%h exp=100/0f", bus.state, bus.cnt); end
   endtask

   task automatic test_illegal_state();
      drive(1'b0, 1'b1, 1'b0, 8'h55);
      tick();
      force dut.cur_state = state_t'(3'b110);
      drive(1'b0, 1'b1, 1'b1, 8'h77);
      #1;
      n_checks++;
      if (bus.state !== 3'b110) begin n_fail++; $display("[TB] FAIL illegal_forced got=%b exp=110", bus.state); end
      tick();
      release dut.cur_state;
      #1;
      n_checks++;
      if (bus.state !== 3'b000 || bus.cnt !== 8'h00 || bus.tc !== 1'b0)
         begin n_fail++; $display("[TB] FAIL illegal_110 got=%b/%h/%b exp=000/00/0", bus.state, bus.cnt, bus.tc); end
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      force dut.cur_state = state_t'(3'b111);
      tick();
      release dut.cur_state;
      #1;
      n_checks++;
      if (bus.state !== 3'b000 || bus.cnt !== 8'h00 || bus.tc !== 1'b0)
         begin n_fail++; $display("[TB] FAIL illegal_111 got=%b/%h/%b exp=000/00/0", bus.state, bus.cnt, bus.tc); end
   endtask

   task automatic test_random();
      logic       c, l, i;
      logic [7:0] d;
      drive(1'b1, 1'b0, 1'b0, 8'h00);
      tick();
      m_mode = 0; m_phase = 0; m_cnt = 0; m_tc = 1'b0;
      i = 1'b1;
      for (int n = 0; n < 400; n++) begin
         c = ($urandom_range(0, 15) == 0);
         l = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 3) == 0) i = ~i;
         d = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 255)) : 8'(8'hFE + $urandom_range(0, 3));
         drive(c, l, i, d);
         if (c) begin
            m_mode = 0; m_cnt = 0; m_tc = 1'b0;
         end else if (l) begin
            m_mode = 1; m_cnt = int'(d); m_tc = 1'b0;
         end else if (i) begin
            m_phase = (m_mode == 2) ? 1 - m_phase : 0;
            m_mode  = 2;
            m_tc    = (m_cnt == 255);
            m_cnt   = (m_cnt + 1) % 256;
         end else begin
            m_phase = (m_mode == 3) ? 1 - m_phase : 0;
            m_mode  = 3;
            m_tc    = (m_cnt == 0);
            m_cnt   = (m_cnt + 255) % 256;
         end
         tick();
         n_checks++;
         if (bus.state !== model_code() || bus.cnt !== 8'(m_cnt) || bus.tc !== m_tc)
            begin n_fail++; $display("[TB] FAIL random_%0d got=%b/%h/%b exp=%b/%h/%b", n,
               bus.state, bus.cnt, bus.tc, model_code(), 8'(m_cnt), m_tc); end
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 8'h00);
      test_reset();
      test_load_count_up();
      test_count_down();
      test_priority();
      test_load_boundary();
      test_direction_flip();
      test_illegal_state();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
